// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RISC-V instruction fetch stage: pc, imem handshake, IR and decoded fields
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [6:0]  OP,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        misaligned_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ir, ir_nxt;
  logic [31:0] ipc, ipc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= 32'h0;
      ipc   <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      ipc   <= ipc_nxt;
    end
  end

  // pc already points past the issued instruction, so only a taken branch rewrites it
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    ipc_nxt   = ipc;
    case (state)
      FETCH: begin
        if (imem_valid) begin
          ir_nxt    = imem_rdata;
          ipc_nxt   = pc;
          pc_nxt    = pc + 32'd4;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (!branch_taken) begin
            state_nxt = FETCH;
          end else if (branch_target[1:0] == 2'b00) begin
            pc_nxt    = branch_target;
            state_nxt = FETCH;
          end else begin
            state_nxt = HALT;
          end
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign imem_req         = (state == FETCH);
  assign imem_addr        = pc;
  assign instr            = ir;
  assign instr_pc         = ipc;
  assign instr_valid      = (state == ISSUE);
  assign misaligned_fault = (state == HALT);

  assign OP     = ir[6:0];
  assign Funct3 = ir[14:12];
  assign Funct7 = ir[31:25];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [6:0]  OP;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        misaligned_fault;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .OP(OP), .Funct3(Funct3), .Funct7(Funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits `waits` cycles with no response, then answers with `word`; the expected IR/instr_pc
  // go onto the scoreboard when the response is driven and are popped once instr_valid rises.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word, input int waits);
    logic [63:0] exp;
    for (int i = 0; i <= waits; i++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        n_err++;
        $display("FAIL fetch_req[%0d]: req=%b addr=%h, expected req=1 addr=%h", i, imem_req, imem_addr, exp_addr);
      end
      if (i < waits) begin
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        step();
      end
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    sb.push_back({word, exp_addr});
    step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_latency: instr_valid=%b one edge after response, expected 1", instr_valid);
    end else if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: instr_valid=1 with nothing expected");
    end else begin
      exp = sb.pop_front();
      if ({instr, instr_pc} !== exp) begin
        n_err++;
        $display("FAIL fetch_ir: instr=%h instr_pc=%h, expected instr=%h instr_pc=%h",
                 instr, instr_pc, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic consume(input logic bt, input logic [31:0] tgt);
    stall         = 1'b0;
    branch_taken  = bt;
    branch_target = tgt;
    step();
    branch_taken  = 1'b0;
    branch_target = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    step(); step();
    n_cmp++;
    if ({imem_req, imem_addr, instr_valid, misaligned_fault} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_ctrl: req=%b addr=%h valid=%b fault=%b, expected 1 0 0 0",
               imem_req, imem_addr, instr_valid, misaligned_fault);
    end
    n_cmp++;
    if ({instr, instr_pc, OP, Funct3, Funct7, rd, rs1, rs2} !== 91'h0) begin
      n_err++;
      $display("FAIL reset_ir: instr=%h instr_pc=%h OP=%h, expected all zero", instr, instr_pc, OP);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fetch_one(32'h0, 32'h0050_0093, 0);
    n_cmp++;
    if ({OP, Funct3, rd, rs1, imem_req} !== {7'b0010011, 3'd0, 5'd1, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_fields: OP=%b F3=%0d rd=%0d rs1=%0d req=%b, expected 0010011 0 1 0 0",
               OP, Funct3, rd, rs1, imem_req);
    end
    consume(1'b0, 32'h0);
    n_cmp++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
      n_err++;
      $display("FAIL basic_next: req=%b addr=%h valid=%b, expected 1 4 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_wait();
    fetch_one(32'h4, 32'h0000_0013, 0);
    consume(1'b0, 32'h0);
    fetch_one(32'h8, 32'h0020_81b3, 3);
    n_cmp++;
    if ({instr_pc, rd, rs1, rs2} !== {32'h8, 5'd3, 5'd1, 5'd2}) begin
      n_err++;
      $display("FAIL wait_fields: instr_pc=%h rd=%0d rs1=%0d rs2=%0d, expected 8 3 1 2", instr_pc, rd, rs1, rs2);
    end
    consume(1'b0, 32'h0);
  endtask

  task automatic test_stall();
    fetch_one(32'hC, 32'h4020_8033, 0);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({instr, Funct7, instr_valid, imem_req, instr_pc} !== {32'h4020_8033, 7'b0100000, 1'b1, 1'b0, 32'hC}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: instr=%h F7=%b valid=%b req=%b, expected 40208033 0100000 1 0",
                 i, instr, Funct7, instr_valid, imem_req);
      end
    end
    consume(1'b0, 32'h0);
    n_cmp++;
    if (imem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL stall_next: addr=%h, expected 00000010", imem_addr);
    end
  endtask

  task automatic test_branch();
    fetch_one(32'h10, 32'h0200_0863, 0);
    consume(1'b1, 32'h40);
    n_cmp++;
    if ({imem_addr, instr_valid, imem_req} !== {32'h40, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL branch_redirect: addr=%h valid=%b req=%b, expected 40 0 1", imem_addr, instr_valid, imem_req);
    end
    fetch_one(32'h40, 32'h0000_0013, 1);
    n_cmp++;
    if (instr_pc !== 32'h40) begin
      n_err++;
      $display("FAIL branch_pc: instr_pc=%h, expected 00000040", instr_pc);
    end
    consume(1'b0, 32'h0);
  endtask

  task automatic test_wrap_and_reset();
    fetch_one(32'h44, 32'h0000_0063, 0);
    consume(1'b1, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'h0000_0013, 0);
    consume(1'b0, 32'h0);
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap: addr=%h, expected 00000000", imem_addr);
    end
    fetch_one(32'h0, 32'h0000_0013, 0);
    consume(1'b0, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_addr, imem_req, instr_valid} !== {32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_midwait: addr=%h req=%b valid=%b, expected 0 1 0", imem_addr, imem_req, instr_valid);
    end
    step();
    rst_n = 1'b1;
    fetch_one(32'h0, 32'h0050_0093, 0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({instr_valid, imem_addr, instr, instr_pc} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_midissue: valid=%b addr=%h instr=%h, expected 0 0 0", instr_valid, imem_addr, instr);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_misaligned();
    fetch_one(32'h0, 32'h0200_0863, 0);
    consume(1'b1, 32'h42);
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'b1;
      n_cmp++;
      if ({misaligned_fault, instr_valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b0, 32'h4}) begin
        n_err++;
        $display("FAIL halt[%0d]: fault=%b valid=%b req=%b addr=%h, expected 1 0 0 4",
                 i, misaligned_fault, instr_valid, imem_req, imem_addr);
      end
      step();
    end
    imem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (misaligned_fault !== 1'b0) begin
      n_err++;
      $display("FAIL halt_reset: fault=%b, expected 0", misaligned_fault);
    end
    step();
    rst_n = 1'b1;
    step();
    fetch_one(32'h0, 32'h0000_0013, 0);
    consume(1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_stall();
    test_branch();
    test_wrap_and_reset();
    test_misaligned();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
